// File: rtl/parking_pkg.sv
// Shared widths, snapshot FSM states and the timestamp record for the
// parking-lot time scheduler.
package parking_pkg;
   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 7;
   localparam int unsigned DAY_W  = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RESP    = 2'd2
   } snap_state_e;

   typedef struct packed {
      logic [DAY_W-1:0]  day;
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  minute;
   } timestamp_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// scanning upward with wrap-around.
module rr_arbiter #(
   parameter int unsigned NUM_GATES = 4,
   parameter int unsigned PTR_W     = $clog2(NUM_GATES)
) (
   input  logic [NUM_GATES-1:0] req_i,
   input  logic [PTR_W-1:0]     ptr_i,
   output logic                 valid_o,
   output logic [PTR_W-1:0]     idx_o
);

   always_comb begin
      int unsigned pos;
      logic [PTR_W-1:0] pos_t;
      valid_o = 1'b0;
      idx_o   = '0;
      pos     = 0;
      pos_t   = '0;
      for (int unsigned i = 0; i < NUM_GATES; i++) begin
         pos = int'(ptr_i) + i;
         if (pos >= NUM_GATES) pos = pos - NUM_GATES;
         pos_t = PTR_W'(pos);
         if (!valid_o && req_i[pos_t]) begin
            valid_o = 1'b1;
            idx_o   = pos_t;
         end
      end
   end

endmodule

// File: rtl/parking_time_sched.sv
// Minute-tick prescaler and clear for the lot's time counter, plus a
// round-robin snapshot server handing coherent timestamps to the gates.
module parking_time_sched
   import parking_pkg::*;
#(
   parameter int unsigned CLKS_PER_MIN = 50,
   parameter int unsigned NUM_GATES    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 clear_time,
   output logic                 cnt_enable,
   output logic                 cnt_reset,
   input  logic [HOUR_W-1:0]    time_hour,
   input  logic [MIN_W-1:0]     time_minute,
   input  logic [DAY_W-1:0]     time_day,
   input  logic [NUM_GATES-1:0] req,
   output logic [NUM_GATES-1:0] ack,
   output logic [HOUR_W-1:0]    ts_hour,
   output logic [MIN_W-1:0]     ts_minute,
   output logic [DAY_W-1:0]     ts_day,
   output logic                 ts_valid,
   output logic                 busy
);

   localparam int unsigned PRESC_W = $clog2(CLKS_PER_MIN);
   localparam int unsigned PTR_W   = $clog2(NUM_GATES);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_MIN - 1);
   localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_GATES - 1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               cnt_enable_q, cnt_reset_q, ev_prev_q;
   logic               tick_due, unsafe;

   snap_state_e        state_q, state_d;
   logic [PTR_W-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   timestamp_t         ts_q, ts_d;
   logic               arb_valid;
   logic [PTR_W-1:0]   arb_idx;

   assign tick_due = run && (presc_q == PRESC_LAST);
   // Counter may be changing during an enable/clear cycle or the one after it.
   assign unsafe   = cnt_enable_q | cnt_reset_q | ev_prev_q;

   always_comb begin
      presc_d = presc_q;
      if (clear_time)         presc_d = '0;
      else if (tick_due)      presc_d = '0;
      else if (run)           presc_d = presc_q + PRESC_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q      <= '0;
         cnt_enable_q <= 1'b0;
         cnt_reset_q  <= 1'b1;
         ev_prev_q    <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         cnt_enable_q <= tick_due & ~clear_time;
         cnt_reset_q  <= clear_time;
         ev_prev_q    <= cnt_enable_q | cnt_reset_q;
      end
   end

   rr_arbiter #(
      .NUM_GATES (NUM_GATES),
      .PTR_W     (PTR_W)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (arb_valid),
      .idx_o   (arb_idx)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      ts_d    = ts_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d = arb_idx;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (!unsafe) begin
               ts_d.day    = time_day;
               ts_d.hour   = time_hour;
               ts_d.minute = time_minute;
               state_d     = RESP;
            end
         end
         RESP: begin
            ptr_d   = (grant_q == PTR_LAST) ? '0 : grant_q + PTR_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         ts_q    <= ts_d;
      end
   end

   assign cnt_enable = cnt_enable_q;
   assign cnt_reset  = cnt_reset_q;
   assign ack        = (state_q == RESP) ? (NUM_GATES'(1) << grant_q) : '0;
   assign ts_valid   = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign ts_day     = ts_q.day;
   assign ts_hour    = ts_q.hour;
   assign ts_minute  = ts_q.minute;

endmodule

// File: tb/tb_parking_time_sched.sv
// Randomized and directed bench for parking_time_sched against a transaction
// level model of the tick schedule and the snapshot service.
module tb_parking_time_sched;
   localparam int N = 50;
   localparam int G = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic       clear_time = 1'b0;
   logic       cnt_enable, cnt_reset;
   logic [4:0] tm_hour = '0;
   logic [6:0] tm_min = '0;
   logic [6:0] tm_day = '0;
   logic [G-1:0] req = '0;
   logic [G-1:0] ack;
   logic [4:0] ts_hour;
   logic [6:0] ts_minute, ts_day;
   logic       ts_valid, busy;

   logic       ld_en = 1'b0;
   logic [4:0] ld_hour = '0;
   logic [6:0] ld_min = '0, ld_day = '0;

   int checks = 0;
   int errors = 0;
   logic compare_en = 1'b0;
   logic [G-1:0] ack_prev = '0;
   int ack_log[$];

   parking_time_sched #(.CLKS_PER_MIN(N), .NUM_GATES(G)) dut (
      .clk(clk), .reset(reset), .run(run), .clear_time(clear_time),
      .cnt_enable(cnt_enable), .cnt_reset(cnt_reset),
      .time_hour(tm_hour), .time_minute(tm_min), .time_day(tm_day),
      .req(req), .ack(ack), .ts_hour(ts_hour), .ts_minute(ts_minute),
      .ts_day(ts_day), .ts_valid(ts_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // The lot's time counter, driven by the DUT's enable and clear.
   always @(posedge clk) begin
      if (ld_en) begin
         tm_day <= ld_day; tm_hour <= ld_hour; tm_min <= ld_min;
      end else if (cnt_reset) begin
         tm_day <= '0; tm_hour <= '0; tm_min <= '0;
      end else if (cnt_enable) begin
         if (tm_min == 7'd59) begin
            tm_min <= '0;
            if (tm_hour == 5'd23) begin tm_hour <= '0; tm_day <= tm_day + 7'd1; end
            else tm_hour <= tm_hour + 5'd1;
         end else tm_min <= tm_min + 7'd1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: prescaler phase, event history and the pending snapshot
   int m_cnt, m_gate, m_resp_gate, m_ptr, m_ts;
   bit m_tick, m_clr, m_ev_prev;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt = 0; m_tick = 0; m_clr = 1; m_ev_prev = 0;
         m_gate = -1; m_resp_gate = -1; m_ptr = 0; m_ts = 0;
      end else begin
         bit unsafe_c, nt;
         unsafe_c = m_tick || m_clr || m_ev_prev;
         nt = run && (m_cnt == N - 1) && !clear_time;
         if (clear_time) m_cnt = 0;
         else if (run) m_cnt = (m_cnt + 1) % N;
         if (m_resp_gate >= 0) begin
            m_ptr = (m_resp_gate + 1) % G;
            m_resp_gate = -1;
         end else if (m_gate >= 0) begin
            if (!unsafe_c) begin
               m_ts = (int'(tm_day) << 12) | (int'(tm_hour) << 7) | int'(tm_min);
               m_resp_gate = m_gate;
               m_gate = -1;
            end
         end else if (req != 0) begin
            for (int k = 0; k < G; k++)
               if (m_gate < 0 && req[(m_ptr + k) % G]) m_gate = (m_ptr + k) % G;
         end
         m_ev_prev = m_tick || m_clr;
         m_tick = nt;
         m_clr = clear_time;
      end
   end

   always @(negedge clk) begin
      if (compare_en) begin
         chk("cnt_enable", int'(cnt_enable), int'(m_tick));
         chk("cnt_reset", int'(cnt_reset), int'(m_clr));
         chk("ack", int'(ack), (m_resp_gate >= 0) ? (1 << m_resp_gate) : 0);
         chk("ts_valid", int'(ts_valid), int'(m_resp_gate >= 0));
         chk("busy", int'(busy), int'(m_gate >= 0 || m_resp_gate >= 0));
         chk("ts", int'({ts_day, ts_hour, ts_minute}), m_ts);
      end
   end

   // One clock; requesters drop req in the cycle after their ack.
   task automatic step();
      @(posedge clk);
      #1;
      req = req & ~ack_prev;
      ack_prev = ack;
      for (int g = 0; g < G; g++) if (ack[g]) ack_log.push_back(g);
   endtask

   task automatic count_to_tick(output int n);
      n = 0;
      do begin step(); n++; end while (!cnt_enable && n < 300);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin step(); n++; end while (ack == 0 && n < 20);
   endtask

   task automatic load_time(input int d, input int h, input int m);
      ld_day = 7'(d); ld_hour = 5'(h); ld_min = 7'(m); ld_en = 1'b1;
      step();
      ld_en = 1'b0;
   endtask

   initial begin
      int n;
      run = 1'b1;
      repeat (3) step();
      compare_en = 1'b1;
      chk("rst_cnt_reset", int'(cnt_reset), 1);
      chk("rst_busy_ack", int'({busy, ts_valid, ack, cnt_enable}), 0);
      reset = 1'b1;
      step();
      chk("cnt_reset_drop", int'(cnt_reset), 0);
      n = 1;
      while (!cnt_enable && n < 300) begin step(); n++; end
      chk("first_tick", n, N);
      count_to_tick(n);
      chk("tick_spacing", n, N);
      step();
      chk("tick_width", int'(cnt_enable), 0);

      // Freeze at prescaler 30 (one cycle already spent above).
      repeat (29) step();
      run = 1'b0;
      repeat (100) step();
      run = 1'b1;
      count_to_tick(n);
      chk("freeze_resume", n, 20);

      // Clear lands in the cycle a tick is due.
      repeat (N - 1) step();
      clear_time = 1'b1;
      step();
      clear_time = 1'b0;
      chk("clear_cnt_reset", int'(cnt_reset), 1);
      chk("clear_no_tick", int'(cnt_enable), 0);
      count_to_tick(n);
      chk("clear_next_tick", n, N);

      // Safe-window snapshot.
      repeat (3) step();
      load_time(3, 14, 27);
      req[1] = 1'b1;
      step();
      chk("snap_busy", int'(busy), 1);
      step();
      chk("snap_ack", int'(ack), 2);
      chk("snap_ts", int'({ts_day, ts_hour, ts_minute}), (3 << 12) | (14 << 7) | 27);
      step();

      // Deferred snapshot across a 9:59 -> 10:00 rollover.
      count_to_tick(n);
      load_time(5, 9, 59);
      repeat (N - 2) step();
      req[0] = 1'b1;
      wait_ack(n);
      chk("defer_latency", n, 4);
      chk("defer_ack", int'(ack), 1);
      chk("defer_ts", int'({ts_day, ts_hour, ts_minute}), (5 << 12) | (10 << 7));
      step();

      // Fairness from a fresh reset.
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      ack_log.delete();
      req = '1;
      n = 0;
      while (ack_log.size() < 4 && n < 80) begin step(); n++; end
      chk("fair_count", ack_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("fair_order", (i < ack_log.size()) ? ack_log[i] : -1, i);
      repeat (2) step();

      // Reset in the middle of a capture clears the pointer.
      req[1] = 1'b1;
      wait_ack(n);
      chk("pre_ack", int'(ack), 2);
      step();
      req[2] = 1'b1;
      step();
      chk("mid_busy", int'(busy), 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_ack", int'(ack), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_cnt_reset", int'(cnt_reset), 1);
      chk("mid_rst_ts", int'({ts_day, ts_hour, ts_minute, ts_valid}), 0);
      req = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      ack_prev = '0;
      req = 4'b1001;
      wait_ack(n);
      chk("ptr_after_reset", int'(ack), 1);
      step();
      req = '0;
      repeat (4) step();

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         run = ($urandom_range(0, 9) != 0);
         clear_time = ($urandom_range(0, 59) == 0);
         ld_en = ($urandom_range(0, 99) == 0);
         ld_day = 7'($urandom_range(0, 127));
         ld_hour = 5'($urandom_range(0, 23));
         ld_min = 7'($urandom_range(0, 59));
         for (int g = 0; g < G; g++) begin
            if (!req[g] && $urandom_range(0, 7) == 0) req[g] = 1'b1;
            else if (req[g] && $urandom_range(0, 49) == 0) req[g] = 1'b0;
         end
         step();
      end
      clear_time = 1'b0;
      ld_en = 1'b0;
      req = '0;
      repeat (6) step();
      compare_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/parking_time_sched.md
Name: parking_time_sched

Overview:
- Controller for the parking lot's day/hour/minute time counter.
- Generates the counter's one-cycle minute-tick enable from the system clock through a prescaler, and issues its synchronous clear.
- Shares the counter's time value among NUM_GATES entry/exit gate requesters. Arbitration is round-robin; each gate uses a req/ack handshake.
- Each granted gate receives a coherent timestamp snapshot, never captured in a cycle where the counter may be updating.

Parameters:
- CLKS_PER_MIN, 50: system clocks per simulated minute; legal range >= 4.
- NUM_GATES, 4: number of timestamp requesters; legal range 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 lets time advance, 0 freezes the prescaler.
- clear_time  in  1  one-cycle pulse requesting a time restart at day 0 00:00.
- cnt_enable  out  1  one-cycle tick to the time counter's enable.
- cnt_reset  out  1  one-cycle synchronous clear to the time counter.
- time_hour  in  5  counter hour, 0..23.
- time_minute  in  7  counter minute, 0..59.
- time_day  in  7  counter day, 0..127.
- req  in  NUM_GATES  per-gate timestamp request, level, held until ack.
- ack  out  NUM_GATES  one-hot, one-cycle grant/response.
- ts_hour  out  5  captured hour.
- ts_minute  out  7  captured minute.
- ts_day  out  7  captured day.
- ts_valid  out  1  high exactly in the ack cycle.
- busy  out  1  high while the snapshot FSM is outside IDLE.

Behaviour:
- Reset (reset=0, asynchronous) forces the following values:
  - cnt_enable=0, cnt_reset=1 (counter held clear during reset), ack=0, ts_*=0, ts_valid=0, busy=0.
  - prescaler=0, rr pointer=0, FSM=IDLE.
- After reset deasserts, cnt_reset drops on the first clk edge.
- Prescaler:
  - Counts 0..CLKS_PER_MIN-1 while run=1 and holds while run=0.
  - In the cycle after it reaches CLKS_PER_MIN-1, it wraps to 0 and cnt_enable=1 for exactly one cycle.
  - First tick: CLKS_PER_MIN cycles after run rises from a cleared prescaler.
- clear_time:
  - The next cycle has cnt_reset=1 for one cycle, and the prescaler goes to 0.
  - A tick due in that same cycle is suppressed, so cnt_enable and cnt_reset are never both 1.
- Unsafe window: a cycle is unsafe when, in the current or the previous cycle, cnt_enable or cnt_reset is 1. Counter outputs are not sampled in an unsafe cycle.
- Snapshot FSM states are IDLE, CAPTURE and RESP.
- IDLE:
  - If req is nonzero, grant the first set bit at or after the rr pointer, scanning upward with wrap.
  - Latch the grant index and go to CAPTURE.
- CAPTURE:
  - If the cycle is safe, register time_* into ts_* and go to RESP.
  - Otherwise stay in CAPTURE. The maximum wait is 2 cycles.
- RESP:
  - ack[grant]=1 and ts_valid=1 for one cycle.
  - rr pointer becomes (grant+1) mod NUM_GATES; go to IDLE.
- Latency:
  - req sampled in IDLE at edge k gives ack at edge k+2 in a safe window, and at k+4 at most.
- Handshake rules:
  - A requester drops req in the cycle after ack. A req still high in that cycle is not re-granted ahead of the other pending gates, because of the rotated pointer.
  - If req is withdrawn before ack, the snapshot still completes. ack pulses for that index and the gate ignores it.
- ts_* hold their value until the next capture.
- Simultaneous events:
  - clear_time during CAPTURE extends the wait by the unsafe window; the snapshot then reads 0:00 day 0.
  - run=0 does not block snapshots.
- No arithmetic is done on time values: widths pass straight through, with no range checks.

Decomposition:
- Package parking_pkg holds:
  - HOUR_W=5, MIN_W=7, DAY_W=7;
  - the FSM state encoding (IDLE/CAPTURE/RESP);
  - a timestamp struct {day, hour, minute}.
- Sub-module rr_arbiter (combinational NUM_GATES-way round-robin pick from req and the pointer) is a natural split. The prescaler and FSM stay in the top level.

Test Plan:
- Tick spacing: reset release, run=1, CLKS_PER_MIN=50 -> first cnt_enable at cycle 50, then every 50 cycles. Each pulse is 1 cycle wide.
- Freeze: run=0 at prescaler 30 for 100 cycles, then run=1 -> next tick exactly 20 cycles after resume.
- Clear collision: clear_time pulses in the cycle a tick is due -> cnt_reset=1 one cycle later, no cnt_enable, next tick 50 cycles later.
- Single snapshot in safe window, time=day 3 14:27, req[1] held -> ack[1]=1 and ts_valid=1 two cycles later, with ts = 3/14/27.
- Snapshot deferral:
  - req[0] rises so CAPTURE coincides with a cnt_enable, moving the time from 59 to 00 and hour 9 to 10.
  - Required: ts = 10:00 (never 9:59 mixed with hour 10); ack arrives within 4 cycles.
- Fairness and reset: req=4'b1111 held, each gate dropping req after its ack -> acks in order 0,1,2,3.
  - Assert reset mid-CAPTURE -> ack=0 and busy=0 immediately, pointer=0.
